// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter: word and RAM handshake types, arbiter
// states, and the dcache address field layout used to build block base addresses.
package cache_mem_arbiter_pkg;
  localparam int WORD_W     = 32;
  localparam int DBLK_W     = 1;
  localparam int DBLK_WORDS = 2**DBLK_W;
  localparam int BYT_W      = 2;
  localparam int IDX_W      = 3;
  localparam int TAG_W      = WORD_W - IDX_W - DBLK_W - BYT_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE, IRD, DRD0, DRD1, DWR0, DWR1, IDONE, DDONE
  } memarb_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [DBLK_W-1:0] blkoff;
    logic [BYT_W-1:0]  bytoff;
  } dcachef_t;

  localparam word_t WORD_BYTES = word_t'(4);

  // States that own the RAM port and drive exactly one strobe.
  function automatic logic is_active(input memarb_state_t s);
    return (s == IRD) || (s == DRD0) || (s == DRD1) || (s == DWR0) || (s == DWR1);
  endfunction
endpackage

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache (1-word refills) and dcache (2-word
// fills/writebacks). All RAM-side signals and load data are registered.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BLK_WORDS = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         iREN,
  input  logic [ADDR_W-1:0]            iaddr,
  output logic                         iwait,
  output word_t                        iload,
  input  logic                         dREN,
  input  logic                         dWEN,
  input  logic [ADDR_W-1:0]            daddr,
  input  word_t [BLK_WORDS-1:0]        dstore,
  output logic                         dwait,
  output word_t [BLK_WORDS-1:0]        dload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [ADDR_W-1:0]            ramaddr,
  output word_t                        ramstore,
  input  word_t                        ramload,
  input  ramstate_t                    ramstate,
  output logic                         ram_err
);

  memarb_state_t         state, state_n;
  logic                  ren_n, wen_n, err_n, last_d, last_d_n;
  word_t                 addr_n, store_n, iload_n, base_q, base_n, dhi_q, dhi_n;
  word_t [BLK_WORDS-1:0] dload_n;
  logic                  grant_i, dreq;
  dcachef_t              dfield;
  word_t                 dbase;
  logic                  unused_offs;

  assign dfield      = dcachef_t'(daddr);
  assign dbase       = {dfield.tag, dfield.idx, {(DBLK_W+BYT_W){1'b0}}};
  assign unused_offs = ^{dfield.blkoff, dfield.bytoff};

  // Dcache wins unless it was served last and the icache is waiting.
  assign dreq    = dREN | dWEN;
  assign grant_i = iREN & (last_d | ~dreq);

  assign iwait = ~(state == IDONE);
  assign dwait = ~(state == DDONE);

  always_comb begin
    state_n  = state;
    ren_n    = ramREN;
    wen_n    = ramWEN;
    addr_n   = ramaddr;
    store_n  = ramstore;
    iload_n  = iload;
    dload_n  = dload;
    base_n   = base_q;
    dhi_n    = dhi_q;
    last_d_n = last_d;
    err_n    = ram_err;

    unique case (state)
      IDLE: begin
        if (grant_i) begin
          state_n = IRD;
          ren_n   = 1'b1;
          addr_n  = iaddr;
        end else if (dWEN) begin
          // A combined read+write request is a writeback; the fill comes later.
          state_n = DWR0;
          wen_n   = 1'b1;
          base_n  = dbase;
          addr_n  = dbase;
          store_n = dstore[0];
          dhi_n   = dstore[1];
        end else if (dREN) begin
          state_n = DRD0;
          ren_n   = 1'b1;
          base_n  = dbase;
          addr_n  = dbase;
        end
      end
      IRD: if (ramstate == ACCESS) begin
        iload_n = ramload;
        ren_n   = 1'b0;
        state_n = IDONE;
      end
      DRD0: if (ramstate == ACCESS) begin
        dload_n[0] = ramload;
        addr_n     = base_q + WORD_BYTES;
        state_n    = DRD1;
      end
      DRD1: if (ramstate == ACCESS) begin
        dload_n[1] = ramload;
        ren_n      = 1'b0;
        state_n    = DDONE;
      end
      DWR0: if (ramstate == ACCESS) begin
        addr_n  = base_q + WORD_BYTES;
        store_n = dhi_q;
        state_n = DWR1;
      end
      DWR1: if (ramstate == ACCESS) begin
        wen_n   = 1'b0;
        state_n = DDONE;
      end
      IDONE: begin
        last_d_n = 1'b0;
        state_n  = IDLE;
      end
      DDONE: begin
        last_d_n = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // ERROR leaves state and strobes untouched, so the same word is retried.
    if (is_active(state) && (ramstate == ERROR))
      err_n = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      base_q   <= '0;
      dhi_q    <= '0;
      last_d   <= 1'b0;
      ram_err  <= 1'b0;
    end else begin
      state    <= state_n;
      ramREN   <= ren_n;
      ramWEN   <= wen_n;
      ramaddr  <= addr_n;
      ramstore <= store_n;
      iload    <= iload_n;
      dload    <= dload_n;
      base_q   <= base_n;
      dhi_q    <= dhi_n;
      last_d   <= last_d_n;
      ram_err  <= err_n;
    end
  end

endmodule
